cd_spi_csr: RTL

- SPI slave front-end that converts an external host's SPI transactions into single-cycle csr_read/csr_write strobes.
- Sits directly upstream of the cdbus top, driving its 5-bit-address / 8-bit-data CSR port.
- Lets an MCU with only SPI access all cdbus registers, including the burst TX/RX data registers.
- One clk domain; SPI pins are oversampled and synchronized, no SPI-clocked logic.

---
 rtl/cd_spi_csr.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/cd_spi_csr.sv
// SPI mode-0 slave that turns host byte streams into single-cycle CSR read/write strobes.
// All SPI pins are oversampled in the clk domain; there is no logic clocked by spi_sclk.
module cd_spi_csr #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_nss,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] nss_sync_reg;
  logic                   sclk_d_reg;
  logic                   nss_d_reg;
  logic                   armed_reg;
  logic                   miso_oe_reg;
  logic [2:0]             bit_cnt_reg;
  logic [7:0]             rx_shift_reg;
  logic [7:0]             tx_shift_reg;
  logic [RD_LAT-1:0]      rd_pipe_reg;
  logic                   csr_read_reg, csr_read_next;
  logic                   csr_write_reg, csr_write_next;
  logic [4:0]             csr_address_reg, csr_address_next;
  logic [7:0]             csr_writedata_reg, csr_writedata_next;

  logic       sclk_s, mosi_s, nss_s;
  logic       sclk_rise, sclk_fall, nss_fall, nss_rise;
  logic       active, byte_done, rd_capture;
  logic [7:0] rx_byte;

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
  assign nss_s  = nss_sync_reg[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s & ~sclk_d_reg & ~nss_s;
  assign sclk_fall  = ~sclk_s & sclk_d_reg & ~nss_s;
  assign nss_fall   = ~nss_s & nss_d_reg;
  assign nss_rise   = nss_s & ~nss_d_reg;
  assign active     = (state_reg != IDLE);
  assign byte_done  = active & sclk_rise & (bit_cnt_reg == 3'd7) & ~nss_fall;
  assign rx_byte    = {rx_shift_reg[6:0], mosi_s};
  // A capture that lands after nss has gone high (state left RD) is dropped.
  assign rd_capture = rd_pipe_reg[RD_LAT-1] & (state_reg == RD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (nss_fall) begin
      state_next = CMD;
    end else if (nss_rise) begin
      state_next = IDLE;
    end else if (byte_done && (state_reg == CMD)) begin
      state_next = rx_byte[7] ? WR : RD;
    end
  end

  always_comb begin
    csr_read_next      = 1'b0;
    csr_write_next     = 1'b0;
    csr_address_next   = csr_address_reg;
    csr_writedata_next = csr_writedata_reg;
    if (byte_done) begin
      case (state_reg)
        CMD: begin
          csr_address_next = rx_byte[4:0];
          csr_read_next    = ~rx_byte[7];
        end
        WR: begin
          csr_write_next     = 1'b1;
          csr_writedata_next = rx_byte;
        end
        RD:      csr_read_next = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_reg     <= '0;
      mosi_sync_reg     <= '0;
      nss_sync_reg      <= '0;
      sclk_d_reg        <= 1'b0;
      nss_d_reg         <= 1'b0;
      armed_reg         <= 1'b0;
      miso_oe_reg       <= 1'b0;
      bit_cnt_reg       <= 3'd0;
      rx_shift_reg      <= 8'h00;
      tx_shift_reg      <= 8'h00;
      rd_pipe_reg       <= '0;
      csr_read_reg      <= 1'b0;
      csr_write_reg     <= 1'b0;
      csr_address_reg   <= 5'd0;
      csr_writedata_reg <= 8'h00;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
      nss_sync_reg  <= {nss_sync_reg[SYNC_STAGES-2:0], spi_nss};
      sclk_d_reg    <= sclk_s;
      nss_d_reg     <= nss_s;
      // The nss synchronizer resets to "selected"; keep MISO undriven until nss is seen high.
      if (nss_s) begin
        armed_reg <= 1'b1;
      end
      miso_oe_reg <= ~nss_s & armed_reg;

      if (nss_fall) begin
        bit_cnt_reg  <= 3'd0;
        rx_shift_reg <= 8'h00;
        tx_shift_reg <= 8'h00;
      end else begin
        if (active && sclk_rise) begin
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
          rx_shift_reg <= rx_byte;
        end
        // The fall right after a byte boundary (bit_cnt 0) keeps the freshly loaded MSB.
        if (rd_capture) begin
          tx_shift_reg <= csr_readdata;
        end else if (active && sclk_fall && (bit_cnt_reg != 3'd0)) begin
          tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
        end
      end

      rd_pipe_reg[0] <= csr_read_reg;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_reg[i] <= rd_pipe_reg[i-1];
      end

      csr_read_reg      <= csr_read_next;
      csr_write_reg     <= csr_write_next;
      csr_address_reg   <= csr_address_next;
      csr_writedata_reg <= csr_writedata_next;
    end
  end

  assign spi_miso      = tx_shift_reg[7];
  assign spi_miso_oe   = miso_oe_reg;
  assign csr_address   = csr_address_reg;
  assign csr_read      = csr_read_reg;
  assign csr_write     = csr_write_reg;
  assign csr_writedata = csr_writedata_reg;

endmodule
